// File: rtl/systolic_mm_engine.sv
// Output-stationary ROWS x COLS systolic matrix-multiply engine: skewed A/B feed
// with stall support, zero-injection flush, then row-by-row result drain.
module systolic_mm_engine #(
  parameter int unsigned ROWS     = 8,
  parameter int unsigned COLS     = 8,
  parameter int unsigned BITS_AB  = 8,
  parameter int unsigned BITS_C   = 16,
  parameter int unsigned MAX_K    = 255,
  parameter bit          SATURATE = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [$clog2(MAX_K+1)-1:0]   k_len,
  input  logic                         acc_clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ROWS-1:0][BITS_AB-1:0] a_vec,
  input  logic [COLS-1:0][BITS_AB-1:0] b_vec,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(ROWS)-1:0]      out_row,
  output logic [COLS-1:0][BITS_C-1:0]  out_data,
  output logic                         busy,
  output logic                         done,
  output logic                         ovf
);
  localparam int unsigned KW = $clog2(MAX_K+1);
  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned FW = $clog2(ROWS+COLS);
  localparam int unsigned CW = (KW > FW) ? KW : FW;
  localparam logic [BITS_C-1:0] C_MAX = {1'b0, {(BITS_C-1){1'b1}}};
  localparam logic [BITS_C-1:0] C_MIN = {1'b1, {(BITS_C-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_FLUSH, S_DRAIN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [KW-1:0]   k_q, k_d;
  logic [RW-1:0]   row_q, row_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;
  logic            in_ready_q, out_valid_q, busy_q;
  logic            adv_c, feed_c, clear_c, start_c;
  logic [ROWS*COLS-1:0] pe_ovf;

  logic [BITS_AB-1:0] a_sk  [ROWS];
  logic [BITS_AB-1:0] b_sk  [COLS];
  logic [BITS_AB-1:0] a_hop [ROWS][COLS];
  logic [BITS_AB-1:0] b_hop [ROWS][COLS];
  logic [BITS_C-1:0]  acc_w [ROWS][COLS];

  // Control: run sequencing and array advance enables
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    row_d   = row_q;
    done_d  = 1'b0;
    adv_c   = 1'b0;
    feed_c  = 1'b0;
    clear_c = 1'b0;
    start_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          start_c = 1'b1;
          k_d     = k_len;
          clear_c = acc_clear;
          cnt_d   = '0;
          row_d   = '0;
          state_d = (k_len == '0) ? S_DRAIN : S_FEED;
        end
      end
      S_FEED: begin
        if (in_valid) begin
          adv_c  = 1'b1;
          feed_c = 1'b1;
          if (cnt_q == CW'(k_q) - CW'(1)) begin
            cnt_d   = '0;
            state_d = S_FLUSH;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_FLUSH: begin
        adv_c = 1'b1;
        if (cnt_q == CW'(ROWS+COLS-2)) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (row_q == RW'(ROWS-1)) begin
            row_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    ovf_d = start_c ? 1'b0 : (ovf_q | (adv_c & (|pe_ovf)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      k_q         <= '0;
      row_q       <= '0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      row_q       <= row_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
      in_ready_q  <= (state_d == S_FEED);
      out_valid_q <= (state_d == S_DRAIN);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  // Input skew: row r / column c see their operand r / c advance steps late
  for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
    logic [BITS_AB-1:0] a_src;
    assign a_src = feed_c ? a_vec[r] : '0;
    if (r == 0) begin : g_direct
      assign a_sk[r] = a_src;
    end else begin : g_delay
      logic [BITS_AB-1:0] sr_q [r];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < r; i++) sr_q[i] <= '0;
        end else if (adv_c) begin
          sr_q[0] <= a_src;
          for (int i = 1; i < r; i++) sr_q[i] <= sr_q[i-1];
        end
      end
      assign a_sk[r] = sr_q[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_b_skew
    logic [BITS_AB-1:0] b_src;
    assign b_src = feed_c ? b_vec[c] : '0;
    if (c == 0) begin : g_direct
      assign b_sk[c] = b_src;
    end else begin : g_delay
      logic [BITS_AB-1:0] sr_q [c];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < c; i++) sr_q[i] <= '0;
        end else if (adv_c) begin
          sr_q[0] <= b_src;
          for (int i = 1; i < c; i++) sr_q[i] <= sr_q[i-1];
        end
      end
      assign b_sk[c] = sr_q[c-1];
    end
  end

  // PE grid: A moves right, B moves down, each PE keeps its own C element
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_pe
      logic signed [BITS_AB-1:0]   a_in, b_in;
      logic signed [2*BITS_AB-1:0] prod;
      logic signed [BITS_C:0]      sum;
      logic signed [BITS_C-1:0]    acc_q;
      logic [BITS_AB-1:0]          ah_q, bh_q;

      if (c == 0) begin : g_a_edge
        assign a_in = a_sk[r];
      end else begin : g_a_int
        assign a_in = a_hop[r][c-1];
      end
      if (r == 0) begin : g_b_edge
        assign b_in = b_sk[c];
      end else begin : g_b_int
        assign b_in = b_hop[r-1][c];
      end

      assign prod = (2*BITS_AB)'(a_in) * (2*BITS_AB)'(b_in);
      assign sum  = (BITS_C+1)'(acc_q) + (BITS_C+1)'(prod);
      assign pe_ovf[r*COLS+c] = sum[BITS_C] ^ sum[BITS_C-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          acc_q <= '0;
          ah_q  <= '0;
          bh_q  <= '0;
        end else if (clear_c) begin
          acc_q <= '0;
        end else if (adv_c) begin
          ah_q <= a_in;
          bh_q <= b_in;
          if (pe_ovf[r*COLS+c] && SATURATE)
            acc_q <= sum[BITS_C] ? C_MIN : C_MAX;
          else
            acc_q <= sum[BITS_C-1:0];
        end
      end

      assign a_hop[r][c] = ah_q;
      assign b_hop[r][c] = bh_q;
      assign acc_w[r][c] = acc_q;
    end
  end

  // Result row mux; zero whenever no row is presented
  always_comb begin
    out_data = '0;
    if (out_valid_q) begin
      for (int c = 0; c < COLS; c++) out_data[c] = acc_w[row_q][c];
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_row   = row_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Bench for systolic_mm_engine: saturating and wrapping 2x2 instances share stimulus
// and are compared against a plain-arithmetic matrix-product model.
module tb_systolic_mm_engine;
  localparam int unsigned R  = 2;
  localparam int unsigned C  = 2;
  localparam int unsigned AB = 8;
  localparam int unsigned CB = 16;
  localparam int unsigned MK = 255;
  localparam int unsigned KW = $clog2(MK+1);
  localparam int unsigned RW = $clog2(R);
  localparam int MAXB = 8;
  localparam longint SMAX = (longint'(1) <<< (CB-1)) - 1;
  localparam longint SMIN = -SMAX - 1;

  logic clk = 1'b0;
  logic rst, start, acc_clear, in_valid, out_ready;
  logic [KW-1:0]         k_len;
  logic [R-1:0][AB-1:0]  a_vec;
  logic [C-1:0][AB-1:0]  b_vec;

  logic s_in_ready, s_out_valid, s_busy, s_done, s_ovf;
  logic w_in_ready, w_out_valid, w_busy, w_done, w_ovf;
  logic [RW-1:0] s_out_row, w_out_row;
  logic [C-1:0][CB-1:0] s_out_data, w_out_data;

  systolic_mm_engine #(.ROWS(R), .COLS(C), .BITS_AB(AB), .BITS_C(CB), .MAX_K(MK), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .acc_clear(acc_clear),
    .in_valid(in_valid), .in_ready(s_in_ready), .a_vec(a_vec), .b_vec(b_vec),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_row(s_out_row), .out_data(s_out_data),
    .busy(s_busy), .done(s_done), .ovf(s_ovf));

  systolic_mm_engine #(.ROWS(R), .COLS(C), .BITS_AB(AB), .BITS_C(CB), .MAX_K(MK), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .acc_clear(acc_clear),
    .in_valid(in_valid), .in_ready(w_in_ready), .a_vec(a_vec), .b_vec(b_vec),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_row(w_out_row), .out_data(w_out_data),
    .busy(w_busy), .done(w_done), .ovf(w_ovf));

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  int a_m [R][MAXB];
  int b_m [MAXB][C];
  longint ms [R][C];
  longint mw [R][C];
  bit os, ow;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Reference: C += A*B with per-product clamping or 16-bit wrap, in k order
  task automatic model(input int k, input bit clr);
    longint p, s, w;
    os = 1'b0;
    ow = 1'b0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        if (clr) begin ms[r][c] = 0; mw[r][c] = 0; end
        for (int kk = 0; kk < k; kk++) begin
          p = longint'(a_m[r][kk]) * longint'(b_m[kk][c]);
          s = ms[r][c] + p;
          if (s > SMAX) begin ms[r][c] = SMAX; os = 1'b1; end
          else if (s < SMIN) begin ms[r][c] = SMIN; os = 1'b1; end
          else ms[r][c] = s;
          w = mw[r][c] + p;
          if (w > SMAX || w < SMIN) ow = 1'b1;
          mw[r][c] = longint'(shortint'(w));
        end
      end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"}, {s_in_ready, w_in_ready}, 0);
    chk({tag, "_out_valid"}, {s_out_valid, w_out_valid}, 0);
    chk({tag, "_busy"}, {s_busy, w_busy}, 0);
    chk({tag, "_done"}, {s_done, w_done}, 0);
    chk({tag, "_ovf"}, {s_ovf, w_ovf}, 0);
    chk({tag, "_out_row"}, {s_out_row, w_out_row}, 0);
    chk({tag, "_out_data"}, {s_out_data, w_out_data}, 0);
  endtask

  task automatic chk_row(input string tag, input int r);
    chk({tag, "_row_s"}, s_out_row, r);
    chk({tag, "_row_w"}, w_out_row, r);
    for (int c = 0; c < C; c++) begin
      chk({tag, "_data_s"}, $signed(s_out_data[c]), ms[r][c]);
      chk({tag, "_data_w"}, $signed(w_out_data[c]), mw[r][c]);
    end
  endtask

  task automatic load_beat(input int kk);
    for (int r = 0; r < R; r++) a_vec[r] = AB'(a_m[r][kk]);
    for (int c = 0; c < C; c++) b_vec[c] = AB'(b_m[kk][c]);
  endtask

  task automatic run(input int k, input bit clr, input bit istall, input int ostall);
    int kk, g;
    bit tog, rdy;
    model(k, clr);
    @(negedge clk);
    chk("pre_start_busy", s_busy, 0);
    start = 1'b1; k_len = KW'(k); acc_clear = clr; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; k_len = KW'($urandom); acc_clear = 1'(($urandom));
    chk("busy_after_start", {s_busy, w_busy}, 3);
    kk = 0; g = 0; tog = 1'b1;
    while (kk < k && g < 2000) begin
      rdy = s_in_ready;
      if (istall && !tog) begin
        in_valid = 1'b0; start = 1'b1;
        a_vec = (R*AB)'($urandom); b_vec = (C*AB)'($urandom);
      end else begin
        in_valid = 1'b1; start = 1'b0;
        load_beat(kk);
      end
      tog = ~tog;
      if (in_valid && rdy) kk++;
      @(negedge clk);
      g++;
    end
    chk("feed_beats", kk, k);
    in_valid = 1'b0; start = 1'b0;
    out_ready = (ostall == 0);
    for (int r = 0; r < R; r++) begin
      g = 0;
      while (!s_out_valid && g < 200) begin @(negedge clk); g++; end
      chk("drain_valid", {s_out_valid, w_out_valid}, 3);
      chk("drain_in_ready", {s_in_ready, w_in_ready}, 0);
      in_valid = 1'(($urandom)); a_vec = (R*AB)'($urandom); b_vec = (C*AB)'($urandom);
      chk_row("drain", r);
      if (ostall > 0) begin
        out_ready = 1'b0;
        repeat (ostall) begin
          @(negedge clk);
          chk_row("stall", r);
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (ostall > 0) out_ready = 1'b0;
    end
    in_valid = 1'b0;
    chk("done_pulse", {s_done, w_done}, 3);
    chk("idle_busy", {s_busy, w_busy}, 0);
    chk("idle_out_valid", {s_out_valid, w_out_valid}, 0);
    chk("idle_out_data", {s_out_data, w_out_data}, 0);
    chk("ovf_s", s_ovf, os);
    chk("ovf_w", w_ovf, ow);
    @(negedge clk);
    chk("done_once", {s_done, w_done}, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; acc_clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    k_len = '0; a_vec = '0; b_vec = '0;
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) begin ms[r][c] = 0; mw[r][c] = 0; end
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;

    // Directed 2x2 product, then stalled, then accumulate-on-top
    a_m[0][0] = 1; a_m[0][1] = 2; a_m[1][0] = 3; a_m[1][1] = 4;
    b_m[0][0] = 5; b_m[0][1] = 6; b_m[1][0] = 7; b_m[1][1] = 8;
    run(2, 1'b1, 1'b0, 0);
    run(2, 1'b1, 1'b1, 3);
    run(2, 1'b0, 1'b0, 0);

    // Saturation versus wrap
    for (int kk = 0; kk < 4; kk++) begin
      for (int r = 0; r < R; r++) a_m[r][kk] = -128;
      for (int c = 0; c < C; c++) b_m[kk][c] = -128;
    end
    run(4, 1'b1, 1'b0, 0);

    // Zero-length run
    run(0, 1'b1, 1'b0, 1);

    // Reset mid-flush together with start
    for (int kk = 0; kk < 2; kk++) begin
      for (int r = 0; r < R; r++) a_m[r][kk] = $urandom_range(0, 255) - 128;
      for (int c = 0; c < C; c++) b_m[kk][c] = $urandom_range(0, 255) - 128;
    end
    @(negedge clk);
    start = 1'b1; k_len = KW'(2); acc_clear = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; load_beat(0);
    @(negedge clk);
    load_beat(1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("in_flush", {s_busy, s_in_ready, w_busy, w_in_ready}, 4'b1010);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    chk_idle("abort");
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("abort_no_start", {s_busy, w_busy}, 0);
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) begin ms[r][c] = 0; mw[r][c] = 0; end
    for (int kk = 0; kk < 3; kk++) begin
      for (int r = 0; r < R; r++) a_m[r][kk] = $urandom_range(0, 255) - 128;
      for (int c = 0; c < C; c++) b_m[kk][c] = $urandom_range(0, 255) - 128;
    end
    run(3, 1'b0, 1'b0, 0);

    // Randomised runs with random stalls and accumulate mode
    for (int i = 0; i < 6; i++) begin
      int k;
      k = $urandom_range(1, 6);
      for (int kk = 0; kk < k; kk++) begin
        for (int r = 0; r < R; r++) a_m[r][kk] = $urandom_range(0, 255) - 128;
        for (int c = 0; c < C; c++) b_m[kk][c] = $urandom_range(0, 255) - 128;
      end
      run(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
